svreal_dot_mac: RTL

- Pipelined, parametrised fixed-point multiply-accumulate engine in svreal's width/exponent number format.
- Computes dot products over a framed stream of (a, b) sample pairs, using first/last tags.
- Emits one accumulated result per frame through a valid/ready output.
- Sits behind svreal-format sources in DSP/model datapaths. It replaces ad-hoc combinational multiply/add chains where throughput and frame-based accumulation are required.

---
 rtl/svreal_dot_mac.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/svreal_dot_mac.sv
// svreal_dot_mac: pipelined fixed-point multiply-accumulate over framed (a, b) streams.
// Inputs and outputs use svreal width/exponent format: value = mantissa * 2^EXP.
// Optional build macro SVREAL_DOT_MAC_SAT_EN: when defined the accumulator saturates
// on overflow; otherwise it wraps two's-complement. ovf_o flags overflow in both builds.
module svreal_dot_mac #(
    parameter int A_WIDTH    = 16,
    parameter int A_EXP      = -8,
    parameter int B_WIDTH    = 17,
    parameter int B_EXP      = -9,
    parameter int ACC_WIDTH  = 32,
    parameter int ACC_EXP    = -12,
    parameter int MUL_STAGES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic signed [A_WIDTH-1:0]   a_i,
    input  logic signed [B_WIDTH-1:0]   b_i,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] acc_o,
    output logic                        ovf_o
);

    // Product width/exponent and the shift that brings it onto the accumulator grid.
    localparam int PW   = A_WIDTH + B_WIDTH;
    localparam int SH   = A_EXP + B_EXP - ACC_EXP;
    localparam int SH_L = (SH > 0) ? SH : 0;
    localparam int SH_R = (SH < 0) ? -SH : 0;
    localparam int AW   = ACC_WIDTH + 1;                       // aligned product width
    localparam int XW   = ((PW > AW) ? PW : AW) + SH_L + 1;    // lossless shift workspace
    localparam int SW   = ACC_WIDTH + 2;                       // exact sum width
    localparam int NS   = MUL_STAGES + 1;                      // product register stages

    if (MUL_STAGES < 0 || MUL_STAGES > 4) begin : g_bad_stages
        $error("svreal_dot_mac: MUL_STAGES must be in 0..4");
    end
    if (ACC_WIDTH < 2) begin : g_bad_acc
        $error("svreal_dot_mac: ACC_WIDTH must be at least 2");
    end

    // Move the product onto the accumulator exponent; right shifts floor toward -inf,
    // then keep ACC_WIDTH+1 bits.
    function automatic logic signed [AW-1:0] align_prod(input logic signed [PW-1:0] p);
        logic signed [XW-1:0] x;
        x = XW'(p);
        x = (x <<< SH_L) >>> SH_R;
        return x[AW-1:0];
    endfunction

    // True when the exact sum does not fit in ACC_WIDTH signed bits.
    function automatic logic sum_ovf(input logic signed [SW-1:0] s);
        logic [2:0] top;
        top = s[SW-1:ACC_WIDTH-1];
        return (|top) && !(&top);
    endfunction

    // Reduce the exact sum to ACC_WIDTH bits: clamp or wrap depending on build.
    function automatic logic signed [ACC_WIDTH-1:0] fit_sum(input logic signed [SW-1:0] s);
`ifdef SVREAL_DOT_MAC_SAT_EN
        if (sum_ovf(s)) begin
            if (s[SW-1]) return {1'b1, {(ACC_WIDTH-1){1'b0}}};
            else         return {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return s[ACC_WIDTH-1:0];
`else
        return s[ACC_WIDTH-1:0];
`endif
    endfunction

    logic                        stall;

    logic signed [A_WIDTH-1:0]   a_p0_q;
    logic signed [B_WIDTH-1:0]   b_p0_q;
    logic                        vld_p0_q;
    logic                        first_p0_q;
    logic                        last_p0_q;

    logic signed [PW-1:0]        prod_p_q  [NS];
    logic                        vld_p_q   [NS];
    logic                        first_p_q [NS];
    logic                        last_p_q  [NS];

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic                        ovf_run_q;
    logic                        ovf_d;
    logic signed [ACC_WIDTH-1:0] acc_o_q;
    logic                        ovf_o_q;
    logic                        out_valid_q;
    logic                        out_valid_d;
    logic                        acc_en;
    logic                        emit;

    logic signed [AW-1:0]        aligned_w;
    logic signed [ACC_WIDTH-1:0] base_w;
    logic signed [SW-1:0]        sum_w;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign acc_o     = acc_o_q;
    assign ovf_o     = ovf_o_q;

    // Input capture and product pipeline; every stage freezes while the output is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_p0_q     <= '0;
            b_p0_q     <= '0;
            vld_p0_q   <= 1'b0;
            first_p0_q <= 1'b0;
            last_p0_q  <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                prod_p_q[k]  <= '0;
                vld_p_q[k]   <= 1'b0;
                first_p_q[k] <= 1'b0;
                last_p_q[k]  <= 1'b0;
            end
        end else if (!stall) begin
            // p0: register operands and frame tags
            a_p0_q     <= a_i;
            b_p0_q     <= b_i;
            vld_p0_q   <= in_valid;
            first_p0_q <= in_first;
            last_p0_q  <= in_last;
            // p1: full-width product
            prod_p_q[0]  <= PW'(a_p0_q) * PW'(b_p0_q);
            vld_p_q[0]   <= vld_p0_q;
            first_p_q[0] <= first_p0_q;
            last_p_q[0]  <= last_p0_q;
            // p2..: extra product delay stages
            for (int k = 1; k < NS; k++) begin
                prod_p_q[k]  <= prod_p_q[k-1];
                vld_p_q[k]   <= vld_p_q[k-1];
                first_p_q[k] <= first_p_q[k-1];
                last_p_q[k]  <= last_p_q[k-1];
            end
        end
    end

    // Align the oldest product and form the next accumulator, overflow and output state.
    always_comb begin
        aligned_w   = align_prod(prod_p_q[NS-1]);
        base_w      = first_p_q[NS-1] ? '0 : acc_q;
        sum_w       = SW'(base_w) + SW'(aligned_w);
        acc_d       = fit_sum(sum_w);
        ovf_d       = (first_p_q[NS-1] ? 1'b0 : ovf_run_q) | sum_ovf(sum_w);
        acc_en      = !stall && vld_p_q[NS-1];
        emit        = acc_en && last_p_q[NS-1];
        out_valid_d = emit || (out_valid_q && !out_ready);
    end

    // Accumulator and result registers; a result is only replaced when it was not stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_run_q   <= 1'b0;
            acc_o_q     <= '0;
            ovf_o_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // final stage: accumulate and emit
            if (acc_en) begin
                acc_q     <= acc_d;
                ovf_run_q <= ovf_d;
            end
            if (emit) begin
                acc_o_q <= acc_d;
                ovf_o_q <= ovf_d;
            end
            out_valid_q <= out_valid_d;
        end
    end

endmodule
